// File: rtl/llc_port_arbiter.sv
// llc_port_arbiter: round-robin arbiter sharing one LLC/memory port among NUM_CORES cores; LLC_ARB_STATS_EN adds per-core grant counters on stat_count
module llc_port_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128,
  localparam int IW = (NUM_CORES > 2) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES-1:0]        core_req_reset,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*LINE_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_ready,
  output logic [LINE_W-1:0]           core_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic [LINE_W-1:0]           mem_rdata,
  input  logic                        mem_ready,
  output logic [IW-1:0]               grant_id,
  output logic [31:0]                 stat_count,
  input  logic [IW-1:0]               stat_sel
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, pick, next_ptr;
  logic [NUM_CORES-1:0] rot;
  logic grant, adv;
  assign grant = (state == IDLE) && |core_req;
  assign next_ptr = (grant_id == IW'(NUM_CORES - 1)) ? '0 : grant_id + 1'b1;
  assign mem_req = state == ISSUE;
  assign core_ready = (state == RESPOND) ? NUM_CORES'(1) << grant_id : '0;
  assign rot = NUM_CORES'({core_req, core_req} >> rr_ptr);
  always_comb begin
    pick = rr_ptr;
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (rot[i]) pick = IW'((int'(rr_ptr) + i) % NUM_CORES);
  end
  always_comb begin
    state_n = state;
    adv = 1'b0;
    case (state)
      IDLE: state_n = |core_req ? ISSUE : IDLE;
      ISSUE: begin
        state_n = !mem_ready ? ISSUE : core_req[grant_id] ? RESPOND : IDLE;
        adv = mem_ready && !core_req[grant_id];
      end
      RESPOND: begin
        adv = core_req_reset[grant_id] || !core_req[grant_id];
        state_n = adv ? IDLE : RESPOND;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      core_rdata <= '0;
    end else begin
      state <= state_n;
      if (adv) rr_ptr <= next_ptr;
      if (grant) begin
        grant_id <= pick;
        mem_we <= core_we[pick];
        mem_addr <= core_addr[pick*ADDR_W +: ADDR_W];
        mem_wdata <= core_wdata[pick*LINE_W +: LINE_W];
      end
      if (state == ISSUE && mem_ready) core_rdata <= mem_rdata;
    end
  end
`ifdef LLC_ARB_STATS_EN
  logic [31:0] cnt [NUM_CORES];
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++)
      cnt[i] <= rst ? '0 : cnt[i] + 32'(grant && pick == IW'(i));
  end
  assign stat_count = (int'(stat_sel) < NUM_CORES) ? cnt[stat_sel] : '0;
`else
  logic unused_sel;
  assign unused_sel = ^stat_sel;
  assign stat_count = '0;
`endif
endmodule
